nios2_computer_nios2_gen2_0_cpu_mult_combine: RTL and testbench
===============================================================

Name: nios2_computer_nios2_gen2_0_cpu_mult_combine

Overview:
Downstream companion of the CPU multiplier cell.
- Sequences the cell: drives its enable and waits out its one-cycle register latency.
- Captures the three 16x16 partial products: p1 = lo*lo, p2 = src1_lo*src2_hi, p3 = src1_hi*src2_lo.
- Reduces them over two registered stages to the low 32 bits of src1*src2 (the MUL instruction result).
- Holds the pipeline stall until the result is valid; also keeps a completed-multiply counter for debug/perf.

Parameters:
- HALF_W, 16, half-operand width; shift amount for the cross terms.
- PP_W, 32, partial product and result width (= 2*HALF_W).
- CNT_W, 16, width of the completed-multiply counter.

Ports:
- clk  in  1  CPU clock.
- reset  in  1  synchronous, active-high reset.
- mul_start  in  1  MUL instruction in E stage, operands valid on the cell inputs.
- mul_flush  in  1  pipeline flush (exception/branch mispredict); abandons the operation in flight.
- cell_en  out  1  enable to the multiplier cell.
- cell_p1  in  PP_W  partial product lo*lo from the cell.
- cell_p2  in  PP_W  partial product src1_lo*src2_hi.
- cell_p3  in  PP_W  partial product src1_hi*src2_lo.
- mul_stall  out  1  stall request to the pipeline.
- mul_result  out  PP_W  low PP_W bits of the product.
- mul_result_valid  out  1  one-cycle pulse when mul_result is new.
- mul_count  out  CNT_W  number of completed (unflushed) multiplies.

Behaviour:
Reset (synchronous, active-high):
- Reset has priority over all other inputs.
- State goes to IDLE; cross_r, p1_r, mul_result and mul_count all clear to 0.
- mul_result_valid, mul_stall and cell_en are 0.

FSM states: IDLE, CELL, SUM, DONE.
- IDLE: if mul_start and not mul_flush, go to CELL.
- CELL: capture p1_r <= cell_p1; capture cross_r <= cell_p2[HALF_W-1:0] + cell_p3[HALF_W-1:0], truncated to HALF_W (carry discarded). Go to SUM.
- SUM: mul_result <= p1_r + {cross_r, HALF_W zeros}, modulo 2^PP_W. Go to DONE.
- DONE: mul_result_valid = 1 and mul_count increments (wraps at 2^CNT_W). If mul_start, go to CELL (back-to-back accepted); otherwise go to IDLE.

Outputs:
- cell_en = mul_start and not mul_flush while in IDLE or DONE, so the cell captures its operands on the same edge the FSM enters CELL. cell_en is 0 in all other states.
- mul_stall = (mul_start and not mul_flush, in IDLE or DONE) or state in {CELL, SUM}. This is combinational from mul_start so the operands are held.

Timing:
- Latency: mul_start seen in cycle 0; mul_result_valid is high in cycle 3.
- mul_stall is high in cycles 0 to 2.
- Throughput: one multiply per 3 cycles.
- mul_result holds its value until the next SUM state completes.

Flush:
- mul_flush in CELL or SUM: next state is IDLE. No valid pulse, no count increment; mul_result keeps its old value.
- mul_flush in DONE: the pulse and count increment still occur (the result was already computed). A simultaneous mul_start is ignored and the next state is IDLE.
- mul_flush in IDLE: blocks start.

Protocol:
- mul_start while in CELL or SUM is a protocol violation and is ignored; the bench asserts it never happens.
- Operands and partial products are unsigned; signedness of the low word is irrelevant (two's-complement identity).

Decomposition:
- Shared package nios2_mul_pkg holds:
  - localparam HALF_W/PP_W defaults;
  - the FSM state enum mul_comb_state_t (2-bit: IDLE=0, CELL=1, SUM=2, DONE=3);
  - the latency constant MUL_LATENCY = 3.
- One natural sub-module, nios2_mul_reduce: the registered two-stage reduction (cross add, shifted final add) with a per-stage enable. The FSM and counter stay in the top module.

Test Plan:
- Reset then idle: all outputs 0, no cell_en for 10 cycles with mul_start=0.
- src1=0x00010002, src2=0x00030004 (p1=0x8, p2=0x6, p3=0x4), start at cycle 0 -> cell_en=1 at cycle 0; stall cycles 0-2; mul_result=0x000A0008 with valid at cycle 3; mul_count=1.
- src1=src2=0xFFFFFFFF (p1=p2=p3=0xFFFE0001) -> cross truncates to 0x0002; mul_result=0x00000001.
- src1=0xFFFFFFFD, src2=7 (p1=0x0006FFEB, p2=0, p3=0x0006FFF9) -> mul_result=0xFFFFFFEB. Then start again in DONE -> next valid exactly 3 cycles later; count=2.
- Start, then mul_flush in SUM -> state IDLE next cycle; no valid pulse; mul_result keeps the previous value; count unchanged.
- Reset asserted in CELL with mul_start high -> all registers 0 next cycle, stall 0; a fresh start afterwards completes normally.

Source files
------------

// File: rtl/nios2_mul_pkg.sv
// Shared definitions for the MUL combine stage that sits after the CPU
// multiplier cell: default operand widths, the sequencer state encoding and
// the start-to-valid latency.
package nios2_mul_pkg;

    localparam int HALF_W      = 16;
    localparam int PP_W        = 2 * HALF_W;
    localparam int MUL_LATENCY = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CELL = 2'd1,
        SUM  = 2'd2,
        DONE = 2'd3
    } mul_comb_state_t;

endpackage

// File: rtl/nios2_computer_nios2_gen2_0_cpu_mult_combine_reduce.sv
// Two registered reduction stages that turn the captured partial products
// into the low PP_W bits of the product.
//   clk, reset : clock, synchronous active-high reset
//   cross_en   : stage 1 enable, captures p1 and the truncated cross sum
//   sum_en     : stage 2 enable, forms p1 + (cross << HALF_W)
//   p1_in      : lo*lo partial product
//   p2_lo      : low half of src1_lo*src2_hi
//   p3_lo      : low half of src1_hi*src2_lo
//   result     : reduced product, held until the next sum_en
module nios2_computer_nios2_gen2_0_cpu_mult_combine_reduce #(
    parameter int HALF_W = nios2_mul_pkg::HALF_W,
    parameter int PP_W   = nios2_mul_pkg::PP_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cross_en,
    input  logic              sum_en,
    input  logic [PP_W-1:0]   p1_in,
    input  logic [HALF_W-1:0] p2_lo,
    input  logic [HALF_W-1:0] p3_lo,
    output logic [PP_W-1:0]   result
);
    import nios2_mul_pkg::*;

    logic [PP_W-1:0]   p1_q,     p1_d;
    logic [HALF_W-1:0] cross_q,  cross_d;
    logic [PP_W-1:0]   result_q, result_d;

    always_comb begin
        p1_d     = p1_q;
        cross_d  = cross_q;
        result_d = result_q;
        if (cross_en) begin
            p1_d    = p1_in;
            // Carry out of the cross sum lands above bit PP_W-1, so drop it.
            cross_d = p2_lo + p3_lo;
        end
        if (sum_en) begin
            result_d = p1_q + {cross_q, {HALF_W{1'b0}}};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            p1_q     <= '0;
            cross_q  <= '0;
            result_q <= '0;
        end else begin
            p1_q     <= p1_d;
            cross_q  <= cross_d;
            result_q <= result_d;
        end
    end

    assign result = result_q;

endmodule

// File: rtl/nios2_computer_nios2_gen2_0_cpu_mult_combine.sv
// Sequencer for the CPU multiplier cell: enables the cell, waits out its
// register latency, reduces the three partial products to the MUL result,
// stalls the pipeline meanwhile and counts completed multiplies.
//   clk, reset        : clock, synchronous active-high reset
//   mul_start         : MUL in E stage, operands valid at the cell
//   mul_flush         : abandon the operation in flight
//   cell_en           : multiplier cell operand capture enable
//   cell_p1/p2/p3     : lo*lo, src1_lo*src2_hi, src1_hi*src2_lo
//   mul_stall         : pipeline stall request
//   mul_result        : low PP_W bits of src1*src2
//   mul_result_valid  : one-cycle pulse when mul_result is new
//   mul_count         : completed (unflushed) multiplies, wrapping
//
// state | meaning
// IDLE  | waiting for mul_start
// CELL  | cell registers hold the partial products; capture stage 1
// SUM   | form the final sum into mul_result
// DONE  | result valid pulse, count; may accept the next start
module nios2_computer_nios2_gen2_0_cpu_mult_combine #(
    parameter int HALF_W = nios2_mul_pkg::HALF_W,
    parameter int PP_W   = nios2_mul_pkg::PP_W,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mul_start,
    input  logic             mul_flush,
    output logic             cell_en,
    input  logic [PP_W-1:0]  cell_p1,
    input  logic [PP_W-1:0]  cell_p2,
    input  logic [PP_W-1:0]  cell_p3,
    output logic             mul_stall,
    output logic [PP_W-1:0]  mul_result,
    output logic             mul_result_valid,
    output logic [CNT_W-1:0] mul_count
);
    import nios2_mul_pkg::*;

    mul_comb_state_t  state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             start_ok;
    logic             accept;
    logic             cross_en;
    logic             sum_en;
    logic             unused_hi;

    // Upper halves of the cross terms only affect product bits above PP_W.
    assign unused_hi = ^{cell_p2[PP_W-1:HALF_W], cell_p3[PP_W-1:HALF_W]};

    assign start_ok = mul_start && !mul_flush;
    assign accept   = start_ok && (state_q == IDLE || state_q == DONE);

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        case (state_q)
            IDLE: if (start_ok) state_d = CELL;
            CELL: state_d = mul_flush ? IDLE : SUM;
            SUM:  state_d = mul_flush ? IDLE : DONE;
            DONE: begin
                // The result is already computed, so a flush here still counts.
                count_d = count_q + CNT_W'(1);
                state_d = start_ok ? CELL : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    assign cross_en = (state_q == CELL);
    assign sum_en   = (state_q == SUM) && !mul_flush;

    // Combinational from mul_start so the cell captures on the edge that
    // enters CELL and the operands are held by the stall in the same cycle.
    assign cell_en          = accept && !reset;
    assign mul_stall        = (accept || state_q == CELL || state_q == SUM) && !reset;
    assign mul_result_valid = (state_q == DONE) && !reset;
    assign mul_count        = count_q;

    nios2_computer_nios2_gen2_0_cpu_mult_combine_reduce #(
        .HALF_W (HALF_W),
        .PP_W   (PP_W)
    ) u_reduce (
        .clk      (clk),
        .reset    (reset),
        .cross_en (cross_en),
        .sum_en   (sum_en),
        .p1_in    (cell_p1),
        .p2_lo    (cell_p2[HALF_W-1:0]),
        .p3_lo    (cell_p3[HALF_W-1:0]),
        .result   (mul_result)
    );

endmodule

// File: tb/tb_nios2_computer_nios2_gen2_0_cpu_mult_combine.sv
module tb_nios2_computer_nios2_gen2_0_cpu_mult_combine;
    import nios2_mul_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        mul_start;
    logic        mul_flush;
    logic        cell_en;
    logic [31:0] cell_p1, cell_p2, cell_p3;
    logic        mul_stall;
    logic [31:0] mul_result;
    logic        mul_result_valid;
    logic [15:0] mul_count;

    logic [31:0] src1, src2;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_res = '0;
    logic [15:0] exp_cnt = '0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          fl;
    } vec_t;

    vec_t vecs[7];

    always #5 clk = ~clk;

    nios2_computer_nios2_gen2_0_cpu_mult_combine dut (
        .clk              (clk),
        .reset            (reset),
        .mul_start        (mul_start),
        .mul_flush        (mul_flush),
        .cell_en          (cell_en),
        .cell_p1          (cell_p1),
        .cell_p2          (cell_p2),
        .cell_p3          (cell_p3),
        .mul_stall        (mul_stall),
        .mul_result       (mul_result),
        .mul_result_valid (mul_result_valid),
        .mul_count        (mul_count)
    );

    // Multiplier cell: registers the three partial products when enabled.
    always @(posedge clk) begin
        if (cell_en) begin
            cell_p1 <= 32'(src1[15:0])  * 32'(src2[15:0]);
            cell_p2 <= 32'(src1[15:0])  * 32'(src2[31:16]);
            cell_p3 <= 32'(src1[31:16]) * 32'(src2[15:0]);
        end
    end

    // No new start may arrive while the operation is in CELL or SUM.
    always @(negedge clk) begin
        if (!reset)
            assert (!(mul_start && mul_stall && !cell_en))
                else $error("protocol: mul_start during CELL/SUM");
    end

    function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] full;
        full = 64'(a) * 64'(b);
        return full[31:0];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One multiply from start; fl=1 flushes in CELL, fl=2 flushes in SUM.
    task automatic do_mul(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int fl, input string nm);
        @(posedge clk); #1;
        src1 = a; src2 = b; mul_start = 1'b1; mul_flush = 1'b0;
        @(negedge clk);
        chk({nm, " cell_en c0"}, 32'(cell_en), 32'd1);
        chk({nm, " stall c0"}, 32'(mul_stall), 32'd1);
        chk({nm, " valid c0"}, 32'(mul_result_valid), 32'd0);
        @(posedge clk); #1;
        mul_start = 1'b0; mul_flush = (fl == 1);
        @(negedge clk);
        chk({nm, " stall c1"}, 32'(mul_stall), 32'd1);
        chk({nm, " cell_en c1"}, 32'(cell_en), 32'd0);
        chk({nm, " valid c1"}, 32'(mul_result_valid), 32'd0);
        @(posedge clk); #1;
        mul_flush = (fl == 2);
        @(negedge clk);
        chk({nm, " stall c2"}, 32'(mul_stall), (fl == 1) ? 32'd0 : 32'd1);
        chk({nm, " valid c2"}, 32'(mul_result_valid), 32'd0);
        @(posedge clk); #1;
        mul_flush = 1'b0;
        @(negedge clk);
        if (fl == 0) begin
            last_res = exp;
            exp_cnt  = exp_cnt + 16'd1;
            chk({nm, " valid c3"}, 32'(mul_result_valid), 32'd1);
        end else begin
            chk({nm, " valid c3"}, 32'(mul_result_valid), 32'd0);
        end
        chk({nm, " result c3"}, mul_result, last_res);
        chk({nm, " stall c3"}, 32'(mul_stall), 32'd0);
        @(posedge clk); #1;
        chk({nm, " count"}, 32'(mul_count), 32'(exp_cnt));
        chk({nm, " valid c4"}, 32'(mul_result_valid), 32'd0);
    endtask

    initial begin
        vecs[0] = '{32'h00010002, 32'h00030004, 32'h000A0008, 0};
        vecs[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 0};
        vecs[2] = '{32'h0000FFFF, 32'h00010001, 32'hFFFFFFFF, 0};
        vecs[3] = '{32'h12345678, 32'h9ABCDEF0, 32'h0, 2};
        vecs[4] = '{32'h00010000, 32'h00010000, 32'h00000000, 0};
        vecs[5] = '{32'hCAFEF00D, 32'h00000003, 32'h0, 1};
        vecs[6] = '{32'h00000000, 32'hDEADBEEF, 32'h00000000, 0};

        reset = 1'b1; mul_start = 1'b0; mul_flush = 1'b0;
        src1 = '0; src2 = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle cell_en", 32'(cell_en), 32'd0);
            chk("idle stall", 32'(mul_stall), 32'd0);
            chk("idle valid", 32'(mul_result_valid), 32'd0);
            chk("idle result", mul_result, 32'd0);
            chk("idle count", 32'(mul_count), 32'd0);
        end

        for (int i = 0; i < 7; i++)
            do_mul(vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].fl, $sformatf("vec%0d", i));

        // Back-to-back: second start accepted in DONE, valid exactly 3 cycles later.
        @(posedge clk); #1;
        src1 = 32'hFFFFFFFD; src2 = 32'h7; mul_start = 1'b1;
        @(posedge clk); #1 mul_start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        src1 = 32'h00000100; src2 = 32'h00000100; mul_start = 1'b1;
        @(negedge clk);
        chk("b2b valid1", 32'(mul_result_valid), 32'd1);
        chk("b2b result1", mul_result, 32'hFFFFFFEB);
        chk("b2b cell_en", 32'(cell_en), 32'd1);
        chk("b2b stall", 32'(mul_stall), 32'd1);
        exp_cnt = exp_cnt + 16'd1;
        @(posedge clk); #1 mul_start = 1'b0;
        @(negedge clk);
        chk("b2b valid c4", 32'(mul_result_valid), 32'd0);
        @(negedge clk);
        chk("b2b valid c5", 32'(mul_result_valid), 32'd0);
        @(negedge clk);
        chk("b2b valid2", 32'(mul_result_valid), 32'd1);
        chk("b2b result2", mul_result, ref_mul(32'h100, 32'h100));
        exp_cnt = exp_cnt + 16'd1;
        last_res = ref_mul(32'h100, 32'h100);
        @(posedge clk); #1;
        chk("b2b count", 32'(mul_count), 32'(exp_cnt));

        // Flush in SUM: old result kept, count unchanged.
        do_mul(32'h0BAD0BAD, 32'h00C0FFEE, 32'h0, 2, "flush_sum");

        // Flush in DONE with a start: pulse and count still happen, start ignored.
        @(posedge clk); #1;
        src1 = 32'h00000009; src2 = 32'h0000000B; mul_start = 1'b1;
        @(posedge clk); #1 mul_start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        mul_start = 1'b1; mul_flush = 1'b1;
        @(negedge clk);
        chk("fdone valid", 32'(mul_result_valid), 32'd1);
        chk("fdone result", mul_result, 32'd99);
        chk("fdone cell_en", 32'(cell_en), 32'd0);
        chk("fdone stall", 32'(mul_stall), 32'd0);
        exp_cnt = exp_cnt + 16'd1;
        last_res = 32'd99;
        @(posedge clk); #1;
        mul_start = 1'b0; mul_flush = 1'b0;
        @(negedge clk);
        chk("fdone idle stall", 32'(mul_stall), 32'd0);
        chk("fdone idle valid", 32'(mul_result_valid), 32'd0);
        chk("fdone count", 32'(mul_count), 32'(exp_cnt));

        // Randomized multiplies against the arithmetic model.
        for (int i = 0; i < 24; i++) begin
            logic [31:0] a, b;
            int r, fl;
            a = $urandom; b = $urandom;
            r = $urandom_range(0, 4);
            fl = (r == 1) ? 1 : (r == 2) ? 2 : 0;
            do_mul(a, b, ref_mul(a, b), fl, $sformatf("rnd%0d", i));
        end

        // Reset while in CELL with mul_start high.
        @(posedge clk); #1;
        src1 = 32'h00050006; src2 = 32'h00070008; mul_start = 1'b1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("rst stall", 32'(mul_stall), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0; mul_start = 1'b0;
        exp_cnt = '0; last_res = '0;
        @(negedge clk);
        chk("rst stall after", 32'(mul_stall), 32'd0);
        chk("rst valid after", 32'(mul_result_valid), 32'd0);
        chk("rst result", mul_result, 32'd0);
        chk("rst count", 32'(mul_count), 32'd0);
        @(negedge clk);
        chk("rst idle valid", 32'(mul_result_valid), 32'd0);
        do_mul(32'h00050006, 32'h00070008, ref_mul(32'h00050006, 32'h00070008), 0, "post_rst");

        repeat (MUL_LATENCY) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
